byte_unstriping: RTL and testbench

Receive-side counterpart of the 4-lane byte striper: takes one byte per lane per cycle (lane 0 most significant), removes inter-lane skew using per-lane deskew FIFOs anchored on a K-coded alignment character, and reassembles the original 32-bit word. Sits after the per-lane 8b/10b decoders and before the parallel datapath consumer in the 1G clock domain.

---
 rtl/unstripe_pkg.sv | 26 ++
 rtl/lane_deskew_fifo.sv | 51 +++++
 rtl/byte_unstriping.sv | 161 ++++++++++++++++
 tb/tb_byte_unstriping.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unstripe_pkg.sv
// Shared types for the 4-lane byte unstriper: lane entry layout, FSM
// states and the alignment-character test used by the deskew logic.
package unstripe_pkg;

    localparam int                LANE_W         = 8;
    localparam int                NUM_LANES      = 4;
    localparam logic [LANE_W-1:0] ALIGN_CHAR_DEF = 8'h7C;   // K28.3

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // One decoded lane symbol: control flag plus byte.
    typedef struct packed {
        logic              k;
        logic [LANE_W-1:0] data;
    } lane_entry_t;

    // True when the symbol is the K-coded alignment character.
    function automatic logic is_align(input lane_entry_t       e,
                                      input logic [LANE_W-1:0] align_char);
        return e.k && (e.data == align_char);
    endfunction

endpackage

// File: rtl/lane_deskew_fifo.sv
// Per-lane deskew FIFO. Synchronous write and read, synchronous flush,
// head entry visible combinationally. The controller guarantees it never
// writes a full FIFO or reads an empty one, so no flags are kept here.
module lane_deskew_fifo
    import unstripe_pkg::*;
#(
    parameter int DEPTH = 8
)
(
    input  logic        clk_1G,
    input  logic        rst_1G,
    input  logic        flush,
    input  logic        wr_en,
    input  lane_entry_t wr_entry,
    input  logic        rd_en,
    output lane_entry_t head
);

    localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

    lane_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Pointer bookkeeping; flush empties the FIFO by realigning both pointers.
    always_ff @(posedge clk_1G or posedge rst_1G) begin
        if (rst_1G) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= next_ptr(wr_ptr);
            if (rd_en) rd_ptr <= next_ptr(rd_ptr);
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_1G) begin
        if (wr_en && !flush) mem[wr_ptr] <= wr_entry;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/byte_unstriping.sv
// Receive-side 4-lane byte unstriper. Each lane starts filling its deskew
// FIFO at its own alignment character; once all four have started, the
// FIFO heads form aligned columns that are reassembled into 32-bit words
// {lane0, lane1, lane2, lane3}.
// Build option UNSTRIPE_ALIGN_STRIP_EN: when defined, alignment columns are
// consumed silently; otherwise they are emitted as 32'h7C7C7C7C.
//
// Handshake: in_valid qualifies all eight lane inputs together and there is
// no ready; every in_valid cycle is accepted. data_valid qualifies data_out
// for exactly that one cycle.
module byte_unstriping
    import unstripe_pkg::*;
#(
    parameter int                DESKEW_DEPTH = 8,
    parameter logic [LANE_W-1:0] ALIGN_CHAR   = ALIGN_CHAR_DEF
)
(
    input  logic        clk_1G,
    input  logic        rst_1G,
    input  logic        in_valid,
    input  logic [7:0]  data_0L,
    input  logic [7:0]  data_1L,
    input  logic [7:0]  data_2L,
    input  logic [7:0]  data_3L,
    input  logic        k_0L,
    input  logic        k_1L,
    input  logic        k_2L,
    input  logic        k_3L,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        aligned,
    output logic        deskew_err,
    output state_t      fsm_state
);

    localparam int               CNT_W      = $clog2(DESKEW_DEPTH + 1);
    localparam logic [CNT_W-1:0] SKEW_LIMIT = CNT_W'(DESKEW_DEPTH);

    state_t               state;
    lane_entry_t          lane_in [NUM_LANES];
    lane_entry_t          head    [NUM_LANES];
    logic [NUM_LANES-1:0] started;
    logic [NUM_LANES-1:0] start_now;
    logic [NUM_LANES-1:0] active;
    logic [NUM_LANES-1:0] lane_wr;
    logic [NUM_LANES-1:0] head_align;
    logic [CNT_W-1:0]     skew_cnt;
    logic [CNT_W-1:0]     skew_cnt_next;
    logic                 all_started;
    logic                 skew_overflow;
    logic                 col_all;
    logic                 lock_err;
    logic                 flush;
    logic                 rd_en;
    logic                 emit_col;
    logic [31:0]          col_word;

    assign lane_in[0] = {k_0L, data_0L};
    assign lane_in[1] = {k_1L, data_1L};
    assign lane_in[2] = {k_2L, data_2L};
    assign lane_in[3] = {k_3L, data_3L};
    assign fsm_state  = state;

    // Lane start detection, skew overflow, head-column classification and FIFO controls.
    always_comb begin
        start_now  = '0;
        head_align = '0;
        lane_wr    = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            start_now[i]  = (state == SEARCH) && in_valid && !started[i] &&
                            is_align(lane_in[i], ALIGN_CHAR);
            head_align[i] = is_align(head[i], ALIGN_CHAR);
        end
        active        = started | start_now;
        all_started   = &active;
        skew_cnt_next = skew_cnt + 1'b1;
        // The leading lane would hold DESKEW_DEPTH entries after this write.
        skew_overflow = (state == SEARCH) && in_valid && (|active) &&
                        (skew_cnt_next == SKEW_LIMIT) && !all_started;
        col_all       = &head_align;
        lock_err      = (state == LOCKED) && in_valid && (|head_align) && !col_all;
        flush         = skew_overflow | lock_err;
        rd_en         = (state == LOCKED) && in_valid && !lock_err;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_wr[i] = in_valid && !flush && ((state == LOCKED) || active[i]);
        end
        col_word = {head[0].data, head[1].data, head[2].data, head[3].data};
`ifdef UNSTRIPE_ALIGN_STRIP_EN
        emit_col = !col_all;
`else
        emit_col = 1'b1;
`endif
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lane_deskew_fifo #(
            .DEPTH    (DESKEW_DEPTH)
        ) u_fifo (
            .clk_1G   (clk_1G),
            .rst_1G   (rst_1G),
            .flush    (flush),
            .wr_en    (lane_wr[g]),
            .wr_entry (lane_in[g]),
            .rd_en    (rd_en),
            .head     (head[g])
        );
    end

    // SEARCH/LOCKED controller with skew counter and registered outputs.
    always_ff @(posedge clk_1G or posedge rst_1G) begin
        if (rst_1G) begin
            state      <= SEARCH;
            started    <= '0;
            skew_cnt   <= '0;
            aligned    <= 1'b0;
            deskew_err <= 1'b0;
            data_valid <= 1'b0;
            data_out   <= '0;
        end else begin
            deskew_err <= 1'b0;
            data_valid <= 1'b0;
            case (state)
                SEARCH: begin
                    if (in_valid) begin
                        if (all_started) begin
                            // Completion takes priority over a coincident overflow.
                            state    <= LOCKED;
                            aligned  <= 1'b1;
                            started  <= '0;
                            skew_cnt <= '0;
                        end else if (skew_overflow) begin
                            deskew_err <= 1'b1;
                            started    <= '0;
                            skew_cnt   <= '0;
                        end else begin
                            started <= active;
                            if (|active) skew_cnt <= skew_cnt_next;
                        end
                    end
                end
                LOCKED: begin
                    if (in_valid) begin
                        if (lock_err) begin
                            state      <= SEARCH;
                            aligned    <= 1'b0;
                            deskew_err <= 1'b1;
                        end else if (emit_col) begin
                            data_out   <= col_word;
                            data_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= SEARCH;
                    aligned <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_unstriping.sv
// Directed bench for byte_unstriping. Per-lane byte streams are built from
// payload words plus explicit skew/filler, and a word scoreboard checks that
// the reassembled output equals the payload order; timing points are pinned
// with hand-computed expectations.
module tb_byte_unstriping;
    import unstripe_pkg::*;

    localparam logic [8:0]  AL          = 9'h17C;   // K28.3 alignment symbol
    localparam logic [8:0]  FL          = 9'h1BC;   // K28.5 idle filler
    localparam logic [31:0] ALIGN_WORD  = 32'h7C7C7C7C;
    localparam logic [31:0] FILL_WORD   = 32'hBCBCBCBC;

    logic        clk_1G = 1'b0;
    logic        rst_1G;
    logic        in_valid;
    logic [7:0]  data_0L, data_1L, data_2L, data_3L;
    logic        k_0L, k_1L, k_2L, k_3L;
    logic [31:0] data_out;
    logic        data_valid;
    logic        aligned;
    logic        deskew_err;
    state_t      fsm_state;

    logic [31:0] exp_q[$];
    logic [8:0]  lq[4][$];
    bit          al_hist[$];
    bit          er_hist[$];
    bit          dv_hist[$];
    logic [31:0] do_hist[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          err_pulses = 0;
    bit          iv_q = 1'b0;
    bit          prev_err = 1'b0;

    byte_unstriping dut (
        .clk_1G     (clk_1G),
        .rst_1G     (rst_1G),
        .in_valid   (in_valid),
        .data_0L    (data_0L),
        .data_1L    (data_1L),
        .data_2L    (data_2L),
        .data_3L    (data_3L),
        .k_0L       (k_0L),
        .k_1L       (k_1L),
        .k_2L       (k_2L),
        .k_3L       (k_3L),
        .data_out   (data_out),
        .data_valid (data_valid),
        .aligned    (aligned),
        .deskew_err (deskew_err),
        .fsm_state  (fsm_state)
    );

    // Clock / reset block
    always #5 clk_1G = ~clk_1G;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // in_valid as seen by the active edge
    always @(posedge clk_1G) iv_q = in_valid;

    // Compare process: every cycle, outputs against the word scoreboard and pulse rules
    always @(negedge clk_1G) begin
        logic [31:0] w;
        if (rst_1G) begin
            prev_err = 1'b0;
        end else begin
            if (data_valid && data_out != FILL_WORD) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stream: got %h expected no word", data_out);
                end else begin
                    w = exp_q.pop_front();
                    check("stream", data_out, w);
                end
            end
            if (!iv_q) check("idle_valid", 32'(data_valid), 32'd0);
            if (prev_err) check("err_pulse_width", 32'(deskew_err), 32'd0);
            if (deskew_err) begin
                err_pulses++;
                check("err_aligned", 32'(aligned), 32'd0);
            end
            prev_err = deskew_err;
        end
    end

    // Driver tasks
    task automatic tick(input bit v, input logic [35:0] col);
        @(negedge clk_1G);
        in_valid         = v;
        {k_0L, data_0L}  = col[35:27];
        {k_1L, data_1L}  = col[26:18];
        {k_2L, data_2L}  = col[17:9];
        {k_3L, data_3L}  = col[8:0];
        @(posedge clk_1G);
        #1;
    endtask

    task automatic add_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) lq[i].push_back({1'b0, w[31-8*i -: 8]});
        exp_q.push_back(w);
    endtask

    task automatic add_align();
        for (int i = 0; i < 4; i++) lq[i].push_back(AL);
`ifndef UNSTRIPE_ALIGN_STRIP_EN
        exp_q.push_back(ALIGN_WORD);
`endif
    endtask

    task automatic add_lane(input int lane, input logic [8:0] b, input int n);
        for (int j = 0; j < n; j++) lq[lane].push_back(b);
    endtask

    // Plays the lane streams column by column; history index t is edge t.
    task automatic run_streams(input int pad, input bit gaps);
        int          n;
        logic [35:0] col;
        logic [35:0] r;
        n = 0;
        for (int i = 0; i < 4; i++) if (lq[i].size() > n) n = lq[i].size();
        n += pad;
        al_hist.delete(); er_hist.delete(); dv_hist.delete(); do_hist.delete();
        for (int t = 0; t < n; t++) begin
            for (int i = 0; i < 4; i++)
                col[35-9*i -: 9] = (lq[i].size() > 0) ? lq[i].pop_front() : FL;
            tick(1'b1, col);
            al_hist.push_back(aligned);
            er_hist.push_back(deskew_err);
            dv_hist.push_back(data_valid);
            do_hist.push_back(data_out);
            if (gaps && aligned) begin
                r[31:0]  = $urandom;
                r[35:32] = 4'($urandom_range(15, 0));
                tick(1'b0, r);
            end
        end
    endtask

    task automatic end_test(input string name, input int err_base, input int err_exp);
        @(negedge clk_1G);
        #1;
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({name, "_err_pulses"}, 32'(err_pulses - err_base), 32'(err_exp));
    endtask

    task automatic do_reset();
        @(negedge clk_1G);
        rst_1G   = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk_1G);
        rst_1G = 1'b0;
    endtask

    initial begin
        int e0;
        rst_1G   = 1'b1;
        in_valid = 1'b0;
        {k_0L, data_0L, k_1L, data_1L, k_2L, data_2L, k_3L, data_3L} = '0;
        repeat (2) @(negedge clk_1G);
        check("rst_data_out", data_out, 32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_aligned", 32'(aligned), 32'd0);
        check("rst_deskew_err", 32'(deskew_err), 32'd0);
        check("rst_state", 32'(fsm_state), 32'(SEARCH));
        rst_1G = 1'b0;

        // Zero skew
        e0 = err_pulses;
        add_align();
        add_word(32'h01020304);
        add_word(32'h05060708);
        run_streams(4, 1'b0);
        check("t1_aligned_e0", 32'(al_hist[0]), 32'd1);
`ifdef UNSTRIPE_ALIGN_STRIP_EN
        check("t1_align_col_valid", 32'(dv_hist[1]), 32'd0);
`else
        check("t1_align_col_valid", 32'(dv_hist[1]), 32'd1);
        check("t1_align_col_word", do_hist[1], ALIGN_WORD);
`endif
        check("t1_word0_valid", 32'(dv_hist[2]), 32'd1);
        check("t1_word0", do_hist[2], 32'h01020304);
        end_test("t1", e0, 0);
        do_reset();

        // Lane 2 lags by 3 cycles
        e0 = err_pulses;
        add_lane(2, FL, 3);
        add_align();
        add_word(32'hA0A1A2A3);
        add_word(32'hA4A5A6A7);
        add_word(32'hA8A9AAAB);
        add_word(32'hACADAEAF);
        run_streams(4, 1'b0);
        check("t2_aligned_e2", 32'(al_hist[2]), 32'd0);
        check("t2_aligned_e3", 32'(al_hist[3]), 32'd1);
        check("t2_word0_valid", 32'(dv_hist[5]), 32'd1);
        check("t2_word0", do_hist[5], 32'hA0A1A2A3);
        end_test("t2", e0, 0);
        do_reset();

        // Lane 3 lags by 8 cycles: overflow, then lock on the clean column
        e0 = err_pulses;
        for (int i = 0; i < 3; i++) begin
            add_lane(i, AL, 1);
            add_lane(i, FL, 7);
        end
        add_lane(3, FL, 8);
        add_align();
        add_word(32'h11223344);
        add_word(32'h55667788);
        run_streams(4, 1'b0);
        check("t3_err_e6", 32'(er_hist[6]), 32'd0);
        check("t3_err_e7", 32'(er_hist[7]), 32'd1);
        check("t3_aligned_e7", 32'(al_hist[7]), 32'd0);
        check("t3_aligned_e8", 32'(al_hist[8]), 32'd1);
        end_test("t3", e0, 1);
        do_reset();

        // Lone alignment byte on lane 1 while locked
        e0 = err_pulses;
        add_align();
        add_word(32'h21222324);
        add_word(32'h25262728);
        lq[0].push_back(9'h0E0);
        lq[1].push_back(AL);
        lq[2].push_back(9'h0E2);
        lq[3].push_back(9'h0E3);
        for (int i = 0; i < 4; i++) add_lane(i, FL, 2);
        add_align();
        add_word(32'h31323334);
        add_word(32'h35363738);
        run_streams(4, 1'b0);
        check("t4_aligned_e3", 32'(al_hist[3]), 32'd1);
        check("t4_err_e4", 32'(er_hist[4]), 32'd1);
        check("t4_aligned_e4", 32'(al_hist[4]), 32'd0);
        check("t4_aligned_e5", 32'(al_hist[5]), 32'd0);
        check("t4_aligned_e6", 32'(al_hist[6]), 32'd1);
        end_test("t4", e0, 1);
        do_reset();

        // in_valid gaps while locked
        e0 = err_pulses;
        add_align();
        add_word(32'h41424344);
        add_word(32'h45464748);
        add_word(32'h494A4B4C);
        add_word(32'h4D4E4F50);
        run_streams(4, 1'b1);
        end_test("t5", e0, 0);
        do_reset();

        // Reset asserted between edges while locked
        e0 = err_pulses;
        add_align();
        add_word(32'hC0C1C2C3);
        add_word(32'hC4C5C6C7);
        run_streams(0, 1'b0);
        check("t6_pre_word", do_hist[2], 32'hC0C1C2C3);
        check("t6_pre_aligned", 32'(al_hist[2]), 32'd1);
        @(negedge clk_1G);
        #2;
        rst_1G   = 1'b1;
        in_valid = 1'b0;
        #1;
        check("t6_rst_data_out", data_out, 32'd0);
        check("t6_rst_valid", 32'(data_valid), 32'd0);
        check("t6_rst_aligned", 32'(aligned), 32'd0);
        check("t6_rst_state", 32'(fsm_state), 32'(SEARCH));
        exp_q.delete();
        @(negedge clk_1G);
        rst_1G = 1'b0;
        for (int j = 0; j < 3; j++) tick(1'b1, {FL, FL, FL, FL});
        check("t6_no_relock_on_fill", 32'(aligned), 32'd0);
        add_align();
        add_word(32'hD0D1D2D3);
        run_streams(4, 1'b0);
        check("t6_relock_e0", 32'(al_hist[0]), 32'd1);
        end_test("t6", e0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
